// File: rtl/tdm_slot_arbiter.sv
// tdm_slot_arbiter
// Shares one registered output channel among N_REQ requesters. In mode 0 each
// requester owns a fixed time slot of SLOT_CYC cycles (one word per slot at most);
// in mode 1 grants rotate work-conserving round-robin from the last granted
// requester. A one-entry output register with valid/ready handshake sits at the
// output, so accepted data appears one cycle after the transfer.
module tdm_slot_arbiter #(
    parameter int N_REQ    = 2,
    parameter int DATA_W   = 8,
    parameter int SLOT_CYC = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [$clog2(N_REQ)-1:0]  out_src,
    input  logic                      out_ready,
    output logic                      slot_tick
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;

    logic [CNT_W-1:0]  slot_cnt_q, slot_cnt_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              slot_used_q, slot_used_d;
    logic [PTR_W-1:0]  last_grant_q, last_grant_d;
    logic              mode_q;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [PTR_W-1:0]  out_src_q, out_src_d;

    logic              cap;
    logic              mode_chg;
    logic              at_last;
    logic              rr_found;
    logic [PTR_W-1:0]  rr_grant;
    logic [PTR_W-1:0]  sel;
    logic [N_REQ-1:0]  ready_c;
    logic              xfer;
    int                rr_idx;

    // Grant selection: slot owner in TDM mode, first valid after last grant in RR mode.
    // A mode change suppresses all grants for that cycle (the bubble).
    always_comb begin
        cap      = !out_valid_q || out_ready;
        mode_chg = (mode != mode_q);
        at_last  = (slot_cnt_q == CNT_W'(SLOT_CYC - 1));

        rr_found = 1'b0;
        rr_grant = last_grant_q;
        rr_idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            rr_idx = int'(last_grant_q) + k;
            if (rr_idx >= N_REQ) rr_idx = rr_idx - N_REQ;
            if (!rr_found && req_valid[rr_idx]) begin
                rr_found = 1'b1;
                rr_grant = PTR_W'(rr_idx);
            end
        end

        ready_c = '0;
        sel     = ptr_q;
        if (!reset && !mode_chg) begin
            if (!mode) begin
                sel = ptr_q;
                if (cap && !slot_used_q) ready_c[ptr_q] = 1'b1;
            end else begin
                sel = rr_grant;
                if (rr_found && cap) ready_c[rr_grant] = 1'b1;
            end
        end
        xfer = |(ready_c & req_valid);
    end

    // Next-state for slot timer, pointers and the output register.
    always_comb begin
        slot_cnt_d   = slot_cnt_q;
        ptr_d        = ptr_q;
        slot_used_d  = slot_used_q;
        last_grant_d = last_grant_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;

        if (mode_chg) begin
            slot_cnt_d  = '0;
            slot_used_d = 1'b0;
        end else if (at_last) begin
            slot_cnt_d  = '0;
            slot_used_d = 1'b0;
            ptr_d       = (ptr_q == PTR_W'(N_REQ - 1)) ? '0 : ptr_q + PTR_W'(1);
        end else begin
            slot_cnt_d = slot_cnt_q + CNT_W'(1);
            if (xfer) slot_used_d = 1'b1;
        end

        if (xfer && mode) last_grant_d = sel;

        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = req_data[int'(sel)*DATA_W +: DATA_W];
            out_src_d   = sel;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any pending output word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt_q   <= '0;
            ptr_q        <= '0;
            slot_used_q  <= 1'b0;
            last_grant_q <= PTR_W'(N_REQ - 1);
            mode_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= '0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            ptr_q        <= ptr_d;
            slot_used_q  <= slot_used_d;
            last_grant_q <= last_grant_d;
            mode_q       <= mode;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
        end
    end

    assign req_ready = ready_c;
    assign slot_tick = !reset && at_last && !mode_chg;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule
